// File: rtl/mem_access_unit_if.sv
// Memory bus interface for mem_access_unit.
// Carries one single-beat valid/ready transaction at a time.
//   bus_valid  request outstanding (master -> slave)
//   bus_we     1 = write, 0 = read
//   bus_addr   word-aligned byte address
//   bus_be     byte enables, bit i covers bus_wdata[8*i +: 8]
//   bus_wdata  lane-steered write data
//   bus_ready  slave completes the transaction this cycle (slave -> master)
//   bus_rdata  read data, meaningful only while bus_ready is 1
interface mem_access_unit_if #(
   parameter int XLEN = 32
);
   logic            bus_valid;
   logic            bus_we;
   logic [XLEN-1:0] bus_addr;
   logic [3:0]      bus_be;
   logic [XLEN-1:0] bus_wdata;
   logic            bus_ready;
   logic [XLEN-1:0] bus_rdata;

   modport master (
      output bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      input  bus_ready, bus_rdata
   );

   modport slave (
      input  bus_valid, bus_we, bus_addr, bus_be, bus_wdata,
      output bus_ready, bus_rdata
   );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access unit for a multicycle core.
// Turns the control unit's fetch/load/store requests into single-beat bus
// transactions, holds the Instr, OldPC and Data registers, steers store
// bytes onto lanes and sign/zero-extends loads. busy stalls the control FSM
// while a transaction is outstanding; misaligned flags a rejected request.
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   adr_src             address select: 0 = pc, 1 = result
//   ir_write            fetch request
//   mem_read            load request
//   mem_write           store request
//   funct3              data access size/sign
//   pc, result, wdata   current PC, computed address, store data
//   instr, old_pc       instruction register and the PC it was fetched from
//   data                extended load data register
//   busy                control unit must hold state and inputs
//   misaligned          one-cycle fault pulse for an illegal request
//   bus                 memory bus (master side)
module mem_access_unit #(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_INSTR = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              adr_src,
   input  logic              ir_write,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [2:0]        funct3,
   input  logic [XLEN-1:0]   pc,
   input  logic [XLEN-1:0]   result,
   input  logic [XLEN-1:0]   wdata,
   output logic [XLEN-1:0]   instr,
   output logic [XLEN-1:0]   old_pc,
   output logic [XLEN-1:0]   data,
   output logic              busy,
   output logic              misaligned,
   mem_access_unit_if.master bus
);
   typedef enum logic {S_IDLE, S_WAIT} state_t;
   typedef enum logic [1:0] {K_FETCH, K_LOAD, K_STORE} kind_t;

   state_t          state, state_next;
   kind_t           kind, kind_q;
   logic [XLEN-1:0] addr;
   logic            req, illegal, accept, done;
   logic [3:0]      be_next;
   logic [XLEN-1:0] wdata_next;

   logic [2:0]      funct3_q;
   logic [1:0]      lane_q;
   logic [XLEN-1:0] pc_q;
   logic            we_q;
   logic [XLEN-1:0] addr_q;
   logic [3:0]      be_q;
   logic [XLEN-1:0] wdata_q;

   logic [7:0]      rd_byte;
   logic [15:0]     rd_half;
   logic [XLEN-1:0] load_ext;

   // Request decode: priority, legality and the bus fields to latch.
   // NOTE: every signal written here gets a default first, so no path
   // leaves one unassigned and no latch is inferred.
   always_comb begin
      addr       = adr_src ? result : pc;
      req        = ir_write | mem_read | mem_write;
      kind       = K_FETCH;
      illegal    = 1'b0;
      be_next    = 4'b0000;
      wdata_next = '0;

      if (mem_write)     kind = K_STORE;
      else if (mem_read) kind = K_LOAD;

      if (kind == K_FETCH) begin
         illegal = (addr[1:0] != 2'b00);
         be_next = 4'b1111;
      end else begin
         case (funct3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = addr[0];
            3'b010:  illegal = (addr[1:0] != 2'b00);
            3'b100:  illegal = (kind == K_STORE);
            3'b101:  illegal = (kind == K_STORE) | addr[0];
            default: illegal = 1'b1;
         endcase
         case (funct3)
            3'b000:  be_next = 4'b0001 << addr[1:0];
            3'b001:  be_next = 4'b0011 << {addr[1], 1'b0};
            3'b010:  be_next = 4'b1111;
            default: be_next = 4'b0000;
         endcase
      end

      // Replicating the store data lets the byte enables alone pick the lane.
      if (kind == K_STORE) begin
         case (funct3)
            3'b000:  wdata_next = {4{wdata[7:0]}};
            3'b001:  wdata_next = {2{wdata[15:0]}};
            default: wdata_next = wdata;
         endcase
      end
   end

   // FSM next state and handshake outputs. Outputs are forced quiet while
   // reset is asserted so nothing is accepted or flagged in that cycle.
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      done       = 1'b0;
      busy       = 1'b0;
      misaligned = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (req && illegal) begin
               misaligned = 1'b1;
            end else if (req) begin
               accept     = 1'b1;
               busy       = 1'b1;
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            // busy drops in the ready cycle so the control FSM advances
            // on the same edge that captures the read data.
            if (bus.bus_ready) begin
               done       = 1'b1;
               state_next = S_IDLE;
            end else begin
               busy = 1'b1;
            end
         end
      endcase
      if (reset) begin
         accept     = 1'b0;
         done       = 1'b0;
         busy       = 1'b0;
         misaligned = 1'b0;
      end
   end

   // Load extraction uses the lane and funct3 latched at request time.
   always_comb begin
      rd_byte = bus.bus_rdata[7:0];
      unique case (lane_q)
         2'd0: rd_byte = bus.bus_rdata[7:0];
         2'd1: rd_byte = bus.bus_rdata[15:8];
         2'd2: rd_byte = bus.bus_rdata[23:16];
         2'd3: rd_byte = bus.bus_rdata[31:24];
      endcase
      rd_half = lane_q[1] ? bus.bus_rdata[31:16] : bus.bus_rdata[15:0];
      case (funct3_q)
         3'b000:  load_ext = {{24{rd_byte[7]}}, rd_byte};
         3'b001:  load_ext = {{16{rd_half[15]}}, rd_half};
         3'b100:  load_ext = {24'h0, rd_byte};
         3'b101:  load_ext = {16'h0, rd_half};
         default: load_ext = bus.bus_rdata;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         kind_q   <= K_FETCH;
         funct3_q <= 3'b000;
         lane_q   <= 2'b00;
         pc_q     <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         be_q     <= 4'b0000;
         wdata_q  <= '0;
         instr    <= RESET_INSTR;
         old_pc   <= '0;
         data     <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            kind_q   <= kind;
            funct3_q <= funct3;
            lane_q   <= addr[1:0];
            pc_q     <= pc;
            we_q     <= (kind == K_STORE);
            addr_q   <= {addr[XLEN-1:2], 2'b00};
            be_q     <= be_next;
            wdata_q  <= wdata_next;
         end
         if (done) begin
            if (kind_q == K_FETCH) begin
               instr  <= bus.bus_rdata;
               old_pc <= pc_q;
            end else if (kind_q == K_LOAD) begin
               data <= load_ext;
            end
         end
      end
   end

   assign bus.bus_valid = (state == S_WAIT);
   assign bus.bus_we    = we_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_be    = be_q;
   assign bus.bus_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases, randomized
// requests against a behavioural model, scoreboard queue and monitor.
module tb_mem_access_unit;
   localparam logic [31:0] RESET_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        adr_src = 1'b0;
   logic        ir_write = 1'b0;
   logic        mem_read = 1'b0;
   logic        mem_write = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] pc = '0;
   logic [31:0] result = '0;
   logic [31:0] wdata = '0;
   logic [31:0] instr, old_pc, data;
   logic        busy, misaligned;

   mem_access_unit_if #(.XLEN(32)) bus_if ();

   mem_access_unit #(.XLEN(32), .RESET_INSTR(RESET_INSTR)) dut (
      .clk        (clk),
      .reset      (reset),
      .adr_src    (adr_src),
      .ir_write   (ir_write),
      .mem_read   (mem_read),
      .mem_write  (mem_write),
      .funct3     (funct3),
      .pc         (pc),
      .result     (result),
      .wdata      (wdata),
      .instr      (instr),
      .old_pc     (old_pc),
      .data       (data),
      .busy       (busy),
      .misaligned (misaligned),
      .bus        (bus_if)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          fault;
      bit          we;
      logic [31:0] addr;
      logic [3:0]  be;
      bit          chk_be;
      logic [31:0] wdata;
      logic [31:0] instr;
      logic [31:0] old_pc;
      logic [31:0] data;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        pend;
   exp_t        mon_e;
   bit          pend_regs = 1'b0;
   logic [31:0] mem [0:255];
   int          checks = 0;
   int          errors = 0;
   int          resp_wait = 0;
   bit          hold_ready = 1'b0;
   bit          late_pulse = 1'b0;
   logic [31:0] m_instr = RESET_INSTR;
   logic [31:0] m_old_pc = '0;
   logic [31:0] m_data = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Memory responder: answers after resp_wait stalled cycles from the model memory.
   initial begin
      bus_if.bus_ready = 1'b0;
      bus_if.bus_rdata = '0;
      forever begin
         @(posedge clk); #1;
         bus_if.bus_ready = 1'b0;
         bus_if.bus_rdata = $urandom;
         if (late_pulse) begin
            bus_if.bus_ready = 1'b1;
            bus_if.bus_rdata = 32'hCAFE_BABE;
            late_pulse = 1'b0;
         end else if (!hold_ready && bus_if.bus_valid) begin
            if (resp_wait == 0) begin
               bus_if.bus_ready = 1'b1;
               bus_if.bus_rdata = mem[bus_if.bus_addr[9:2]];
            end else begin
               resp_wait--;
            end
         end
      end
   end

   // Monitor: compares every bus cycle / fault pulse against the scoreboard head.
   always @(negedge clk) begin
      if (pend_regs) begin
         check("instr", instr, pend.instr);
         check("old_pc", old_pc, pend.old_pc);
         check("data", data, pend.data);
         pend_regs = 1'b0;
      end
      if (!reset && (bus_if.bus_valid || misaligned)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_event", {30'b0, bus_if.bus_valid, misaligned}, 32'h0);
         end else begin
            mon_e = exp_q[0];
            check("misaligned", misaligned, mon_e.fault);
            check("bus_valid", bus_if.bus_valid, !mon_e.fault);
            if (bus_if.bus_valid && !mon_e.fault) begin
               check("bus_we", bus_if.bus_we, mon_e.we);
               check("bus_addr", bus_if.bus_addr, mon_e.addr);
               if (mon_e.chk_be) check("bus_be", bus_if.bus_be, mon_e.be);
               if (mon_e.we) check("bus_wdata", bus_if.bus_wdata, mon_e.wdata);
               if (bus_if.bus_ready) begin
                  void'(exp_q.pop_front());
                  pend = mon_e;
                  pend_regs = 1'b1;
               end
            end else if (!bus_if.bus_valid) begin
               check("busy_on_fault", busy, 0);
               void'(exp_q.pop_front());
               pend = mon_e;
               pend_regs = 1'b1;
            end
         end
      end
   end

   // Reference model plus driver. Called at posedge+1; returns at posedge+1
   // after the request has completed or been rejected.
   task automatic issue(input bit mw, input bit mr, input bit iw, input bit [2:0] f3,
                        input bit src, input bit [31:0] p, input bit [31:0] r,
                        input bit [31:0] wd, input int w);
      exp_t        e;
      bit [31:0]   a, word, sh;
      int          size, busy_n, exp_busy;
      bit          any, is_store, is_load, is_fetch, uns, legal;
      a        = src ? r : p;
      any      = mw | mr | iw;
      is_store = mw;
      is_load  = !mw && mr;
      is_fetch = !mw && !mr && iw;
      uns      = f3[2];
      if (is_fetch) size = 4;
      else begin
         case (f3[1:0])
            2'd0:    size = 1;
            2'd1:    size = 2;
            2'd2:    size = 4;
            default: size = 0;
         endcase
      end
      legal = (size != 0) && (is_fetch || !(uns && (is_store || size == 4)))
              && ((a % size) == 0);
      e.fault  = any && !legal;
      e.we     = is_store;
      e.addr   = {a[31:2], 2'b00};
      e.chk_be = !is_load;
      e.be     = is_fetch ? 4'hF : 4'(((1 << size) - 1) << (a % 4));
      e.wdata  = (size == 1) ? {4{wd[7:0]}} : (size == 2) ? {2{wd[15:0]}} : wd;
      if (any && legal) begin
         word = mem[a[9:2]];
         if (is_fetch) begin
            m_instr  = word;
            m_old_pc = p;
         end else if (is_load) begin
            sh = word >> (8 * (a % 4));
            if (size == 1)      m_data = uns ? {24'h0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
            else if (size == 2) m_data = uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            else                m_data = word;
         end else begin
            for (int i = 0; i < 4; i++)
               if (e.be[i]) mem[a[9:2]][8*i +: 8] = e.wdata[8*i +: 8];
         end
      end
      e.instr  = m_instr;
      e.old_pc = m_old_pc;
      e.data   = m_data;
      if (any) exp_q.push_back(e);

      resp_wait = w;
      mem_write = mw; mem_read = mr; ir_write = iw;
      funct3 = f3; adr_src = src; pc = p; result = r; wdata = wd;
      busy_n = 0;
      @(negedge clk);
      while (busy && busy_n < 40) begin
         busy_n++;
         @(negedge clk);
      end
      if (busy) check("busy_timeout", busy, 0);
      exp_busy = (any && legal) ? w + 1 : 0;
      check("busy_cycles", busy_n, exp_busy);
      @(posedge clk); #1;
      mem_write = 1'b0; mem_read = 1'b0; ir_write = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit [2:0]  rq;
      bit [31:0] ra;
      for (int i = 0; i < 256; i++) mem[i] = $urandom;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_instr", instr, RESET_INSTR);
      check("reset_old_pc", old_pc, 0);
      check("reset_data", data, 0);
      check("reset_bus_valid", bus_if.bus_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_misaligned", misaligned, 0);
      check("reset_bus_be", bus_if.bus_be, 0);
      check("reset_bus_addr", bus_if.bus_addr, 0);
      @(posedge clk); #1;

      // Fetch with three stall cycles.
      mem[8'h40] = 32'h0050_0093;
      issue(0, 0, 1, 3'b000, 0, 32'h100, 32'h0, 32'h0, 3);
      check("fetch_instr", instr, 32'h0050_0093);
      check("fetch_old_pc", old_pc, 32'h100);
      // LB / LBU from lane 3.
      mem[8'h80] = 32'h80FF_1234;
      issue(0, 1, 0, 3'b000, 1, 32'h0, 32'h203, 32'h0, 1);
      check("lb_data", data, 32'hFFFF_FF80);
      issue(0, 1, 0, 3'b100, 1, 32'h0, 32'h203, 32'h0, 0);
      check("lbu_data", data, 32'h0000_0080);
      // SH to upper half.
      issue(1, 0, 0, 3'b001, 1, 32'h0, 32'h102, 32'hDEAD_BEEF, 2);
      check("sh_data_kept", data, 32'h0000_0080);
      // Faults: misaligned LW, store with funct3=100.
      issue(0, 1, 0, 3'b010, 1, 32'h0, 32'h106, 32'h0, 0);
      issue(1, 0, 0, 3'b100, 1, 32'h0, 32'h104, 32'h1111_2222, 0);
      // Store beats a simultaneous fetch.
      issue(1, 0, 1, 3'b010, 1, 32'h300, 32'h208, 32'h1234_5678, 1);
      check("instr_kept", instr, 32'h0050_0093);

      for (int n = 0; n < 200; n++) begin
         rq = 3'($urandom_range(0, 7));
         ra = $urandom;
         if ($urandom_range(0, 1) == 1) ra[1:0] = 2'b00;
         issue(rq[0], rq[1], rq[2], 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
               ra, ra, $urandom, $urandom_range(0, 3));
      end

      // Reset while a fetch is stalled in WAIT, then a late ready.
      hold_ready = 1'b1;
      exp_q.push_back('{fault: 1'b0, we: 1'b0, addr: 32'h40, be: 4'hF, chk_be: 1'b1,
                        wdata: 32'h0, instr: m_instr, old_pc: m_old_pc, data: m_data});
      pc = 32'h40; adr_src = 1'b0; ir_write = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1; ir_write = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      m_instr = RESET_INSTR; m_old_pc = '0; m_data = '0;
      hold_ready = 1'b0;
      late_pulse = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_reset_bus_valid", bus_if.bus_valid, 0);
         check("post_reset_busy", busy, 0);
      end
      check("post_reset_instr", instr, RESET_INSTR);
      check("post_reset_old_pc", old_pc, 0);
      check("post_reset_data", data, 0);

      repeat (2) @(negedge clk);
      check("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Sits directly downstream of the multicycle control unit, between the datapath and the unified instruction/data memory bus.
- Turns the unit's fetch, load and store requests into single-beat transactions on a valid/ready memory bus.
- Holds the architectural Instr, OldPC and Data registers, performs byte-lane steering and load sign/zero-extension, and asserts busy so the control FSM holds its state while memory is slow.

Parameters:
- XLEN, 32, datapath and bus width; only 32 is supported.
- RESET_INSTR, 32'h00000013, value loaded into instr on reset (RISC-V NOP).

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high
- adr_src  input  1  address select: 0 = pc, 1 = result
- ir_write  input  1  instruction fetch request
- mem_read  input  1  data load request
- mem_write  input  1  data store request
- funct3  input  3  access size/sign for data accesses
- pc  input  XLEN  current PC
- result  input  XLEN  ALU/result-bus address
- wdata  input  XLEN  store data (rs2)
- instr  output  XLEN  instruction register
- old_pc  output  XLEN  PC of the instruction held in instr
- data  output  XLEN  extended load data register
- busy  output  1  control unit must hold state and inputs
- misaligned  output  1  one-cycle fault pulse
- bus_valid  output  1  transaction request
- bus_we  output  1  1 = write
- bus_addr  output  XLEN  word-aligned address ({addr[31:2],2'b00})
- bus_be  output  4  byte enables
- bus_wdata  output  XLEN  lane-steered write data
- bus_ready  input  1  memory completes transaction this cycle
- bus_rdata  input  XLEN  read data, valid when bus_ready is 1

Behaviour:
- Address and requests:
  - addr = adr_src ? result : pc.
  - A request is ir_write | mem_read | mem_write, sampled only in IDLE.
  - Priority is mem_write > mem_read > ir_write; lower-priority requests in the same cycle are dropped.
- States:
  - IDLE: a legal request latches bus_* registers; next state is WAIT.
  - WAIT: bus_valid=1. On bus_ready=1, bus_valid drops next cycle and the next state is IDLE.
- Bus fields held stable for the whole WAIT state: bus_addr, bus_we, bus_be, bus_wdata.
- busy is combinational: busy = (IDLE & legal request) | (WAIT & !bus_ready).
  - busy is 0 in the bus_ready cycle, so the control FSM advances on the same edge that captures the data.
  - Minimum latency is 2 cycles: request cycle plus ready cycle.
- Callers hold all inputs stable while busy=1.
- Fetch:
  - Always a word access; funct3 is ignored.
  - On completion: instr <= bus_rdata and old_pc <= the pc latched at request.
- Load, by funct3:
  - 000 LB: sign-extend byte at lane addr[1:0].
  - 001 LH: sign-extend half at lane addr[1].
  - 010 LW: full word.
  - 100 LBU: zero-extend byte.
  - 101 LHU: zero-extend half.
  - Result goes to data on completion.
- Store, by funct3:
  - 000 SB: be = 4'b0001 << addr[1:0]; wdata[7:0] replicated to all lanes.
  - 001 SH: be = 4'b0011 << {addr[1],1'b0}; wdata[15:0] replicated.
  - 010 SW: be = 4'b1111.
  - For every other funct3, bus_be = 0 on reads.
- Illegal or misaligned request (checked in IDLE):
  - Conditions: halfword with addr[0]=1; word or fetch with addr[1:0]!=0; data access with funct3 in {011,110,111}; store with funct3 in {100,101}.
  - Response: no bus transaction, misaligned=1 for that cycle only, busy=0, and instr, old_pc and data unchanged.
- data updates only on load completion; instr and old_pc update only on fetch completion.
- bus_ready while bus_valid=0 is ignored.
- Reset, including mid-WAIT:
  - Next state IDLE; bus_valid=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0.
  - instr=RESET_INSTR, old_pc=0, data=0, misaligned=0; busy=0 after reset.
  - A bus_ready arriving after reset is ignored.

Test Plan:
- Fetch, pc=0x100, ready asserted 3 cycles after valid -> busy high 4 cycles; instr=bus_rdata=0x00500093; old_pc=0x100; bus_be=1111, bus_we=0.
- LB at result=0x203, adr_src=1, bus_rdata=0x80FF_1234 -> bus_addr=0x200; data=0xFFFFFF80. Repeat with LBU -> data=0x00000080.
- SH at 0x102, wdata=0xDEADBEEF -> bus_be=1100, bus_wdata=0xBEEFBEEF, bus_we=1; data and instr unchanged.
- LW at 0x106 -> misaligned pulses 1 cycle, bus_valid stays 0, busy=0. Store with funct3=100 -> same fault response.
- mem_write and ir_write in the same cycle -> only the store is issued, bus_we=1, instr unchanged.
- reset in WAIT, then late bus_ready=1 -> bus_valid=0 the cycle after reset; instr=0x00000013; no register captures the late data.
